// File: rtl/text_seg_pkg.sv
// Shared types and width helpers for the text line segmenter.
package text_seg_pkg;

    localparam int unsigned DefDataWidth   = 8;
    localparam int unsigned DefImageWidth  = 131;
    localparam int unsigned DefImageHeight = 185;
    localparam int unsigned DefThreshold   = 128;

    typedef enum logic [1:0] {
        S_GAP,
        S_LINE,
        S_EMIT,
        S_DONE
    } seg_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/text_line_segmenter_if.sv
// Pixel-in / segment-out handshake bundle of the text line segmenter.
interface text_line_segmenter_if
    import text_seg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned IMAGE_HEIGHT = DefImageHeight
);
    localparam int unsigned RW = cnt_width(IMAGE_HEIGHT);
    localparam int unsigned LW = cnt_width(IMAGE_HEIGHT + 1);

    logic                  pix_valid;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_ready;
    logic                  seg_valid;
    logic                  seg_ready;
    logic [RW-1:0]         seg_top;
    logic [RW-1:0]         seg_bottom;
    logic                  frame_done;
    logic [LW-1:0]         line_count;

    // Pixel source / segment consumer side.
    modport master (
        output pix_valid, pix_data, seg_ready,
        input  pix_ready, seg_valid, seg_top, seg_bottom, frame_done, line_count
    );

    // Segmenter side.
    modport slave (
        input  pix_valid, pix_data, seg_ready,
        output pix_ready, seg_valid, seg_top, seg_bottom, frame_done, line_count
    );

endinterface

// File: rtl/text_line_segmenter_row_ink_counter.sv
// Threshold compare, column/row counters and per-row ink count.
// Macro SEG_INVERT_EN selects light-on-dark ink polarity.
module row_ink_counter
    import text_seg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned IMAGE_WIDTH  = DefImageWidth,
    parameter int unsigned IMAGE_HEIGHT = DefImageHeight,
    parameter int unsigned THRESHOLD    = DefThreshold,
    parameter int unsigned MIN_INK      = 1,
    localparam int unsigned RW          = cnt_width(IMAGE_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_fire_i,
    input  logic [DATA_WIDTH-1:0] pix_data_i,
    input  logic                  clear_i,
    output logic                  row_end_o,
    output logic [RW-1:0]         row_o,
    output logic                  text_o,
    output logic                  last_row_o
);
    localparam int unsigned CW = cnt_width(IMAGE_WIDTH);
    localparam logic [DATA_WIDTH-1:0] Thresh  = DATA_WIDTH'(THRESHOLD);
    localparam logic [CW-1:0]         ColLast = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0]         RowLast = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0]         ColOne  = CW'(1);
    localparam logic [RW-1:0]         RowOne  = RW'(1);
    localparam logic [CW:0]           InkOne  = (CW + 1)'(1);
    localparam logic [CW:0]           MinInk  = (CW + 1)'(MIN_INK);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW:0]   ink_q, ink_d;
    logic          is_ink;
    logic [CW:0]   ink_sum;
    logic          col_last;

`ifdef SEG_INVERT_EN
    assign is_ink = (pix_data_i >= Thresh);
`else
    assign is_ink = (pix_data_i < Thresh);
`endif

    // Saturating count including the pixel currently on the bus.
    assign ink_sum  = (is_ink && (ink_q != '1)) ? ink_q + InkOne : ink_q;
    assign col_last = (col_q == ColLast);

    assign row_end_o  = pix_fire_i && col_last;
    assign row_o      = row_q;
    assign text_o     = (ink_sum >= MinInk);
    assign last_row_o = (row_q == RowLast);

    // Next-state for column, row and ink counters.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        ink_d = ink_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
            ink_d = '0;
        end else if (pix_fire_i) begin
            if (col_last) begin
                col_d = '0;
                ink_d = '0;
                row_d = last_row_o ? '0 : row_q + RowOne;
            end else begin
                col_d = col_q + ColOne;
                ink_d = ink_sum;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            ink_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            ink_q <= ink_d;
        end
    end

endmodule

// File: rtl/text_line_segmenter.sv
// Finds runs of ink rows in a raster pixel stream and reports them as
// (top, bottom) segments. Macro SEG_INVERT_EN selects light-on-dark ink.
module text_line_segmenter
    import text_seg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned IMAGE_WIDTH  = DefImageWidth,
    parameter int unsigned IMAGE_HEIGHT = DefImageHeight,
    parameter int unsigned THRESHOLD    = DefThreshold,
    parameter int unsigned MIN_INK      = 1,
    parameter int unsigned MIN_LINE_H   = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    text_line_segmenter_if.slave bus
);
    localparam int unsigned RW = cnt_width(IMAGE_HEIGHT);
    localparam int unsigned LW = cnt_width(IMAGE_HEIGHT + 1);
    localparam logic [RW-1:0] RowOne = RW'(1);
    localparam logic [RW:0]   ExtOne = (RW + 1)'(1);
    localparam logic [RW:0]   MinH   = (RW + 1)'(MIN_LINE_H);
    localparam logic [LW-1:0] LineOne = LW'(1);

    seg_state_e    state_q, state_d;
    logic [RW-1:0] top_q, top_d;
    logic [RW-1:0] seg_top_q, seg_top_d;
    logic [RW-1:0] seg_bottom_q, seg_bottom_d;
    logic [LW-1:0] lines_q, lines_d;
    logic [LW-1:0] line_count_q, line_count_d;
    logic          frame_end_q, frame_end_d;

    logic          pix_ready;
    logic          pix_fire;
    logic          clear;
    logic          row_end;
    logic [RW-1:0] row;
    logic          text;
    logic          last_row;
    logic          close;
    logic [RW-1:0] close_top;
    logic [RW-1:0] close_bottom;

    assign pix_ready = (state_q == S_GAP) || (state_q == S_LINE);
    assign pix_fire  = bus.pix_valid && pix_ready;

    row_ink_counter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .THRESHOLD   (THRESHOLD),
        .MIN_INK     (MIN_INK)
    ) u_row_ink_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_fire_i(pix_fire),
        .pix_data_i(bus.pix_data),
        .clear_i   (clear),
        .row_end_o (row_end),
        .row_o     (row),
        .text_o    (text),
        .last_row_o(last_row)
    );

    // Row-end decisions, segment close/emit and end-of-frame bookkeeping.
    always_comb begin
        state_d      = state_q;
        top_d        = top_q;
        seg_top_d    = seg_top_q;
        seg_bottom_d = seg_bottom_q;
        lines_d      = lines_q;
        line_count_d = line_count_q;
        frame_end_d  = frame_end_q;
        clear        = 1'b0;
        close        = 1'b0;
        close_top    = top_q;
        close_bottom = row;

        unique case (state_q)
            S_GAP: begin
                if (row_end) begin
                    if (text) begin
                        top_d     = row;
                        close_top = row;
                        if (last_row) close = 1'b1;
                        else          state_d = S_LINE;
                    end else if (last_row) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LINE: begin
                if (row_end) begin
                    if (!text) begin
                        close        = 1'b1;
                        close_bottom = row - RowOne;
                    end else if (last_row) begin
                        close = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (bus.seg_ready) begin
                    lines_d = lines_q + LineOne;
                    state_d = frame_end_q ? S_DONE : S_GAP;
                end
            end
            S_DONE: begin
                lines_d = '0;
                clear   = 1'b1;
                state_d = S_GAP;
            end
            default: state_d = S_GAP;
        endcase

        if (close) begin
            // Height check done one bit wider so bottom+1 cannot wrap.
            if (({1'b0, close_bottom} + ExtOne) >= ({1'b0, close_top} + MinH)) begin
                seg_top_d    = close_top;
                seg_bottom_d = close_bottom;
                frame_end_d  = last_row;
                state_d      = S_EMIT;
            end else begin
                state_d = last_row ? S_DONE : S_GAP;
            end
        end

        // Publish the count on the edge that enters S_DONE, alongside frame_done.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            line_count_d = lines_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_GAP;
            top_q        <= '0;
            seg_top_q    <= '0;
            seg_bottom_q <= '0;
            lines_q      <= '0;
            line_count_q <= '0;
            frame_end_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            top_q        <= top_d;
            seg_top_q    <= seg_top_d;
            seg_bottom_q <= seg_bottom_d;
            lines_q      <= lines_d;
            line_count_q <= line_count_d;
            frame_end_q  <= frame_end_d;
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.seg_valid  = (state_q == S_EMIT);
    assign bus.seg_top    = seg_top_q;
    assign bus.seg_bottom = seg_bottom_q;
    assign bus.frame_done = (state_q == S_DONE);
    assign bus.line_count = line_count_q;

endmodule
